// File: rtl/ysyx_23060184_mem_arbiter_if.sv
// Shared memory-path signals between IFU/LSU masters, the granted slave and the arbiter.
// The master modport is the environment side (masters plus slave responses).
interface ysyx_23060184_mem_arbiter_if;
  logic        i_arvalid;
  logic        i_rready;
  logic [31:0] d_araddr;
  logic        d_arvalid;
  logic        d_rready;
  logic [31:0] d_awaddr;
  logic        d_awvalid;
  logic        d_bready;
  logic        s_rvalid;
  logic        s_bvalid;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_err;

  modport master (
    output i_arvalid, i_rready, d_araddr, d_arvalid, d_rready,
    output d_awaddr, d_awvalid, d_bready, s_rvalid, s_bvalid,
    input  grant, busy, timeout_err
  );

  modport slave (
    input  i_arvalid, i_rready, d_araddr, d_arvalid, d_rready,
    input  d_awaddr, d_awvalid, d_bready, s_rvalid, s_bvalid,
    output grant, busy, timeout_err
  );
endinterface

// File: rtl/ysyx_23060184_mem_arbiter.sv
// Round-robin arbiter holding the shared AXI4-Lite path for one whole IFU or LSU transaction,
// with LSU address decode (SRAM vs UART) and a watchdog for hung slaves.
module ysyx_23060184_mem_arbiter #(
  parameter logic [31:0] UART_BASE      = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE      = 32'h8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                         clk,
  input logic                         rstn,
  ysyx_23060184_mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {StIdle, StIfuRd, StLsuRd, StLsuWr} state_e;

  localparam logic [1:0]  GrantEmpty = 2'b00;
  localparam logic [1:0]  GrantInst  = 2'b01;
  localparam logic [1:0]  GrantData  = 2'b10;
  localparam logic [1:0]  GrantUart  = 2'b11;
  localparam logic        WdEnable   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WdLast     = 32'(TIMEOUT_CYCLES - 1);
  // 33-bit window bounds so BASE+SIZE never wraps past the top of the address space.
  localparam logic [32:0] UartLo     = {1'b0, UART_BASE};
  localparam logic [32:0] UartHi     = {1'b0, UART_BASE} + {1'b0, UART_SIZE};

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_lsu_q, last_lsu_d;
  logic [31:0] wd_q, wd_d;
  logic        terr_q, terr_d;

  logic        ifu_req, lsu_req, pick_ifu, lsu_uart, release_hs, wd_expire;
  logic [32:0] lsu_addr;

  always_comb begin
    ifu_req   = bus.i_arvalid;
    lsu_req   = bus.d_arvalid | bus.d_awvalid;
    pick_ifu  = ifu_req & (~lsu_req | last_lsu_q);
    lsu_addr  = {1'b0, (bus.d_arvalid ? bus.d_araddr : bus.d_awaddr)};
    lsu_uart  = (lsu_addr >= UartLo) && (lsu_addr < UartHi);
    wd_expire = WdEnable && (wd_q == WdLast);
    unique case (state_q)
      StIfuRd: release_hs = bus.s_rvalid & bus.i_rready;
      StLsuRd: release_hs = bus.s_rvalid & bus.d_rready;
      StLsuWr: release_hs = bus.s_bvalid & bus.d_bready;
      default: release_hs = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_lsu_d = last_lsu_q;
    wd_d       = wd_q;
    terr_d     = 1'b0;
    if (state_q == StIdle) begin
      wd_d = '0;
      if (pick_ifu) begin
        state_d    = StIfuRd;
        grant_d    = GrantInst;
        last_lsu_d = 1'b0;
      end else if (lsu_req) begin
        state_d    = bus.d_arvalid ? StLsuRd : StLsuWr;
        grant_d    = lsu_uart ? GrantUart : GrantData;
        last_lsu_d = 1'b1;
      end
    end else if (release_hs) begin
      state_d = StIdle;
      grant_d = GrantEmpty;
      wd_d    = '0;
    end else if (wd_expire) begin
      state_d = StIdle;
      grant_d = GrantEmpty;
      wd_d    = '0;
      terr_d  = 1'b1;
    end else begin
      wd_d = wd_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      grant_q    <= GrantEmpty;
      last_lsu_q <= 1'b1;
      wd_q       <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_lsu_q <= last_lsu_d;
      wd_q       <= wd_d;
      terr_q     <= terr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Directed bench for the memory arbiter: grant timing, round-robin, UART decode, watchdog, reset.
module tb_ysyx_23060184_mem_arbiter;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  ysyx_23060184_mem_arbiter_if bus ();

  ysyx_23060184_mem_arbiter #(
    .UART_BASE      (32'ha000_03f8),
    .UART_SIZE      (32'h8),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_arvalid = 1'b0;
    bus.i_rready  = 1'b0;
    bus.d_araddr  = 32'h0;
    bus.d_arvalid = 1'b0;
    bus.d_rready  = 1'b0;
    bus.d_awaddr  = 32'h0;
    bus.d_awvalid = 1'b0;
    bus.d_bready  = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.s_bvalid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [31:0] addr_tbl [5];
  logic [1:0]  gnt_tbl  [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    clear_inputs();
    addr_tbl = '{32'ha000_03f8, 32'ha000_0400, 32'ha000_03ff, 32'ha000_03f7, 32'hffff_ffff};
    gnt_tbl  = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10};

    #3;
    check_eq("reset_grant", 32'(bus.grant), 32'h0);
    check_eq("reset_busy", 32'(bus.busy), 32'h0);
    check_eq("reset_terr", 32'(bus.timeout_err), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // IFU only
    step();
    check_eq("idle_grant", 32'(bus.grant), 32'h0);
    bus.i_arvalid = 1'b1;
    step();
    check_eq("ifu_grant", 32'(bus.grant), 32'h1);
    check_eq("ifu_busy", 32'(bus.busy), 32'h1);
    bus.i_arvalid = 1'b0;
    step();
    step();
    check_eq("ifu_hold", 32'(bus.grant), 32'h1);
    bus.s_rvalid = 1'b1;
    bus.i_rready = 1'b1;
    step();
    check_eq("ifu_release", 32'(bus.grant), 32'h0);
    check_eq("ifu_rel_busy", 32'(bus.busy), 32'h0);
    clear_inputs();

    // Contention round-robin from reset
    do_reset();
    bus.i_arvalid = 1'b1;
    bus.d_arvalid = 1'b1;
    bus.d_araddr  = 32'h8000_0000;
    for (int t = 0; t < 4; t++) begin
      step();
      check_eq($sformatf("rr_grant%0d", t), 32'(bus.grant), (t % 2 == 0) ? 32'h1 : 32'h2);
      if (t % 2 == 1) begin
        bus.s_rvalid = 1'b1;
        bus.i_rready = 1'b1;
        step();
        check_eq("rr_wrong_ready", 32'(bus.grant), 32'h2);
        bus.i_rready = 1'b0;
        bus.d_rready = 1'b1;
      end else begin
        bus.s_rvalid = 1'b1;
        bus.i_rready = 1'b1;
      end
      step();
      check_eq($sformatf("rr_bubble%0d", t), 32'(bus.grant), 32'h0);
      bus.s_rvalid = 1'b0;
      bus.i_rready = 1'b0;
      bus.d_rready = 1'b0;
    end
    clear_inputs();
    step();
    check_eq("rr_idle", 32'(bus.grant), 32'h0);

    // UART window decode on writes
    bus.d_awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.d_awaddr = addr_tbl[k];
      step();
      check_eq($sformatf("dec_%0h", addr_tbl[k]), 32'(bus.grant), 32'(gnt_tbl[k]));
      bus.d_awaddr = 32'h1234_0000;
      bus.s_rvalid = 1'b1;
      bus.d_rready = 1'b1;
      step();
      check_eq("wr_ignore_r", 32'(bus.grant), 32'(gnt_tbl[k]));
      bus.s_rvalid = 1'b0;
      bus.d_rready = 1'b0;
      bus.s_bvalid = 1'b1;
      bus.d_bready = 1'b1;
      step();
      check_eq("wr_release", 32'(bus.grant), 32'h0);
      bus.s_bvalid = 1'b0;
      bus.d_bready = 1'b0;
    end
    clear_inputs();

    // Simultaneous LSU read and write: read first, decode on d_araddr
    bus.d_arvalid = 1'b1;
    bus.d_awvalid = 1'b1;
    bus.d_araddr  = 32'h8000_0010;
    bus.d_awaddr  = 32'ha000_03f8;
    step();
    check_eq("rw_read_first", 32'(bus.grant), 32'h2);
    bus.s_bvalid = 1'b1;
    bus.d_bready = 1'b1;
    step();
    check_eq("rw_ignore_b", 32'(bus.grant), 32'h2);
    bus.s_bvalid = 1'b0;
    bus.d_bready = 1'b0;
    bus.s_rvalid = 1'b1;
    bus.d_rready = 1'b1;
    step();
    check_eq("rw_release", 32'(bus.grant), 32'h0);
    clear_inputs();
    step();

    // Hung slave: expiry after 16 busy cycles
    bus.i_arvalid = 1'b1;
    step();
    check_eq("wd_grant", 32'(bus.grant), 32'h1);
    bus.i_arvalid = 1'b0;
    repeat (15) step();
    check_eq("wd_last_busy", 32'(bus.grant), 32'h1);
    check_eq("wd_no_err_yet", 32'(bus.timeout_err), 32'h0);
    step();
    check_eq("wd_expire_grant", 32'(bus.grant), 32'h0);
    check_eq("wd_expire_err", 32'(bus.timeout_err), 32'h1);
    step();
    check_eq("wd_err_pulse", 32'(bus.timeout_err), 32'h0);

    // Handshake on the expiry cycle wins
    bus.i_arvalid = 1'b1;
    step();
    check_eq("wd2_grant", 32'(bus.grant), 32'h1);
    bus.i_arvalid = 1'b0;
    repeat (15) step();
    bus.s_rvalid = 1'b1;
    bus.i_rready = 1'b1;
    step();
    check_eq("wd2_release", 32'(bus.grant), 32'h0);
    check_eq("wd2_no_err", 32'(bus.timeout_err), 32'h0);
    clear_inputs();
    step();
    check_eq("wd2_no_err_after", 32'(bus.timeout_err), 32'h0);

    // Asynchronous reset mid-transaction
    bus.d_arvalid = 1'b1;
    bus.d_araddr  = 32'h8000_0000;
    step();
    check_eq("ar_grant", 32'(bus.grant), 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("ar_async_grant", 32'(bus.grant), 32'h0);
    check_eq("ar_async_busy", 32'(bus.busy), 32'h0);
    bus.i_arvalid = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    step();
    check_eq("ar_ifu_first", 32'(bus.grant), 32'h1);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
